pbvi_policy_exec: RTL and testbench
===================================

PBVI_POLICY_EXEC -- requirements
Module: pbvi_policy_exec

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: policy_load  in  1  one-cycle pulse capturing a solved policy (driven from solver en_solved).
REQ-004 SHALL have ports: alpha_in  in  16x2x16  alpha vectors [0:15][0:1], unsigned Q0.16.
REQ-005 SHALL have ports: action_in  in  16x2  action per alpha vector.
REQ-006 SHALL have ports: trans  in  3x2x2x16  trans[a][s][s'], Q0.16; observe  in  3x2x2x16  observe[a][s'][o], Q0.16; both static while policy_ok=1.
REQ-007 SHALL have ports: belief_init  in  16  initial P(state 0), Q0.16.
REQ-008 SHALL have ports: obs_valid  in  1; obs  in  1  observation index; obs_ready  out  1.
REQ-009 SHALL have ports: act_valid  out  1; act_ready  in  1; action  out  2.
REQ-010 SHALL have ports: belief_out  out  16  current b0; policy_ok  out  1  policy captured.

Function
REQ-011 SHALL use states IDLE, SCAN, OUT, WAIT_OBS, UPDATE, DIV; b1 is defined as 0xFFFF-b0 throughout.
REQ-012 SHALL, on policy_load in any state, register alpha_in/action_in, set belief to belief_init and policy_ok=1, zero the scan index and best value, and enter SCAN next cycle; policy_load has priority over every other event.
REQ-013 SHALL in SCAN evaluate one vector per cycle, i=0..15: v=alpha[i][0]*b0+alpha[i][1]*b1 (33-bit, no truncation), replacing best only on strictly greater, so ties keep the lower index; 16 cycles total.
REQ-014 SHALL enter OUT the cycle after i=15, driving act_valid=1 and action=captured action of best index; action stays stable until handshake.
REQ-015 SHALL on act_valid&&act_ready latch the last action a and enter WAIT_OBS.
REQ-016 SHALL drive obs_ready=1 only in WAIT_OBS with policy_load=0; obs_valid&&obs_ready captures obs and enters UPDATE.
REQ-017 SHALL in UPDATE (1 cycle) compute p0=(T[a][0][0]*b0+T[a][1][0]*b1)>>16, p1=(T[a][0][1]*b0+T[a][1][1]*b1)>>16, un0=(O[a][0][obs]*p0)>>16, un1=(O[a][1][obs]*p1)>>16, all truncating.
REQ-018 SHALL in DIV run a sequential restoring divide, 17 cycles, b0'=floor((un0<<16)/(un0+un1)) saturated to 0xFFFF, then write belief and enter SCAN.
REQ-019 SHALL, if un0+un1==0, skip division, leave belief unchanged and enter SCAN the cycle after UPDATE.
REQ-020 SHALL treat a==3 (undefined) as a=2 for trans/observe indexing.
REQ-021 SHALL keep act_valid=0 and obs_ready=0 outside OUT and WAIT_OBS respectively; belief_out always reflects the registered belief.

Reset
REQ-022 SHALL on rst asynchronously force: state IDLE, policy_ok=0, act_valid=0, obs_ready=0, action=0, belief_out=0, captured policy, index and divider state to 0.
REQ-023 SHALL stay in IDLE after reset release until policy_load; reset mid-operation discards any pending action or observation.

Configuration
REQ-024 SHALL, when PBVI_EXEC_STEP_CNT_EN is defined, add output step_cnt (16) counting action handshakes, saturating at 0xFFFF, cleared by rst and by policy_load.
REQ-025 SHALL, when PBVI_EXEC_STEP_CNT_EN is undefined, omit step_cnt entirely, with all other behaviour identical.

Verification
REQ-026 Reset: assert rst mid-SCAN -> all outputs 0, state IDLE, obs_ready=0 until next policy_load.
REQ-027 Tie: all alpha=0, action_in[0]=1, policy_load -> act_valid high exactly 17 cycles after pulse, action=1.
REQ-028 Argmax: alpha[5]=(0xFFFF,0), others (0x4000,0x4000), action_in[5]=2, belief_init=0x8000 -> action=2.
REQ-029 Update: a=2, trans[2]=((0xFFFF,0),(0,0xFFFF)), observe[2]=((55706,9830),(9830,55706)), b0=0x8000, obs=0 -> un0=27852, un1=4914, belief_out=55707 after DIV, then new SCAN.
REQ-030 Zero evidence: observe[a] all 0 -> belief_out unchanged, SCAN entered after 1 UPDATE cycle, no DIV.
REQ-031 Preempt: policy_load while act_valid=1 and act_ready=0 -> act_valid low next cycle, rescan with belief_init; with PBVI_EXEC_STEP_CNT_EN, step_cnt 0 then increments by 1 per handshake.

Source files
------------

// File: rtl/pbvi_policy_exec.sv
// rtl/pbvi_policy_exec.sv - belief-tracking policy executor for a 2-state, 3-action POMDP
// Optional feature macro: PBVI_EXEC_STEP_CNT_EN adds the step_cnt action-handshake counter.
module pbvi_policy_exec (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         policy_load,
  input  logic [15:0][1:0][15:0]       alpha_in,
  input  logic [15:0][1:0]             action_in,
  input  logic [2:0][1:0][1:0][15:0]   trans,
  input  logic [2:0][1:0][1:0][15:0]   observe,
  input  logic [15:0]                  belief_init,
  input  logic                         obs_valid,
  input  logic                         obs,
  output logic                         obs_ready,
  output logic                         act_valid,
  input  logic                         act_ready,
  output logic [1:0]                   action,
  output logic [15:0]                  belief_out,
  output logic                         policy_ok
`ifdef PBVI_EXEC_STEP_CNT_EN
  ,
  output logic [15:0]                  step_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
    S_OUT      = 3'd2,
    S_WAIT_OBS = 3'd3,
    S_UPDATE   = 3'd4,
    S_DIV      = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Captured policy and belief
  logic [15:0][1:0][15:0] alpha_q, alpha_d;
  logic [15:0][1:0]       act_tab_q, act_tab_d;
  logic [15:0]            belief_q, belief_d;
  logic                   policy_ok_q, policy_ok_d;

  // Argmax scan
  logic [3:0]             idx_q, idx_d;
  logic [32:0]            best_q, best_d;
  logic [3:0]             best_idx_q, best_idx_d;

  // Last executed action and observation
  logic [1:0]             last_act_q, last_act_d;
  logic                   obs_q, obs_d;

  // Restoring divider: den = un0 + un1, dividend = un0 << 16
  logic [16:0]            den_q, den_d;
  logic [16:0]            rem_q, rem_d;
  logic [16:0]            dbits_q, dbits_d;
  logic [16:0]            quo_q, quo_d;
  logic [4:0]             cnt_q, cnt_d;

  // Combinational datapath values
  logic [15:0]            b1;
  logic [32:0]            scan_val;
  logic [1:0][1:0][15:0]  t_row;
  logic [1:0][1:0][15:0]  o_row;
  logic [32:0]            p0_sum, p1_sum;
  logic [15:0]            p0, p1;
  logic [31:0]            un0_prod, un1_prod;
  logic [15:0]            un0, un1;
  logic [16:0]            un_sum;
  logic [17:0]            div_trial;
  logic                   div_ge;
  logic [16:0]            div_quo;
  logic                   act_fire, obs_fire;

  // Arithmetic: scan value, Bayesian prediction/correction, one divider step
  always_comb begin
    b1       = 16'hFFFF - belief_q;
    scan_val = 33'(alpha_q[idx_q][0]) * 33'(belief_q) + 33'(alpha_q[idx_q][1]) * 33'(b1);

    // Action code 3 is undefined and shares the model of action 2
    case (last_act_q)
      2'd0:    begin t_row = trans[0]; o_row = observe[0]; end
      2'd1:    begin t_row = trans[1]; o_row = observe[1]; end
      default: begin t_row = trans[2]; o_row = observe[2]; end
    endcase

    p0_sum   = 33'(t_row[0][0]) * 33'(belief_q) + 33'(t_row[1][0]) * 33'(b1);
    p1_sum   = 33'(t_row[0][1]) * 33'(belief_q) + 33'(t_row[1][1]) * 33'(b1);
    p0       = 16'(p0_sum >> 16);
    p1       = 16'(p1_sum >> 16);
    un0_prod = 32'(o_row[0][obs_q]) * 32'(p0);
    un1_prod = 32'(o_row[1][obs_q]) * 32'(p1);
    un0      = 16'(un0_prod >> 16);
    un1      = 16'(un1_prod >> 16);
    un_sum   = 17'(un0) + 17'(un1);

    div_trial = {rem_q, dbits_q[16]};
    div_ge    = (div_trial >= 18'(den_q));
    div_quo   = (quo_q << 1) | 17'(div_ge);
  end

  // Output decode from the registered state
  always_comb begin
    act_valid  = (state_q == S_OUT);
    obs_ready  = (state_q == S_WAIT_OBS) && !policy_load;
    action     = act_valid ? act_tab_q[best_idx_q] : 2'd0;
    belief_out = belief_q;
    policy_ok  = policy_ok_q;
    act_fire   = act_valid && act_ready;
    obs_fire   = obs_valid && obs_ready;
  end

  // Next-state: policy_load preempts everything
  always_comb begin
    state_d = state_q;
    if (policy_load) begin
      state_d = S_SCAN;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_IDLE;
        S_SCAN:     if (idx_q == 4'd15) state_d = S_OUT;
        S_OUT:      if (act_fire) state_d = S_WAIT_OBS;
        S_WAIT_OBS: if (obs_fire) state_d = S_UPDATE;
        S_UPDATE:   state_d = (un_sum == 17'd0) ? S_SCAN : S_DIV;
        S_DIV:      if (cnt_q == 5'd16) state_d = S_SCAN;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values per state
  always_comb begin
    alpha_d     = alpha_q;
    act_tab_d   = act_tab_q;
    belief_d    = belief_q;
    policy_ok_d = policy_ok_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    last_act_d  = last_act_q;
    obs_d       = obs_q;
    den_d       = den_q;
    rem_d       = rem_q;
    dbits_d     = dbits_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;

    if (policy_load) begin
      alpha_d     = alpha_in;
      act_tab_d   = action_in;
      belief_d    = belief_init;
      policy_ok_d = 1'b1;
    end else begin
      case (state_q)
        S_SCAN: begin
          // Strictly greater keeps the lowest index on ties
          if (scan_val > best_q) begin
            best_d     = scan_val;
            best_idx_d = idx_q;
          end
          idx_d = idx_q + 4'd1;
        end
        S_OUT: begin
          if (act_fire) last_act_d = action;
        end
        S_WAIT_OBS: begin
          if (obs_fire) obs_d = obs;
        end
        S_UPDATE: begin
          // Quotient never exceeds 2^16, so only 17 quotient bits are produced:
          // preload the remainder with dividend>>17 and feed bit 16 first.
          den_d   = un_sum;
          rem_d   = 17'(un0 >> 1);
          dbits_d = {un0[0], 16'd0};
          quo_d   = 17'd0;
          cnt_d   = 5'd0;
        end
        S_DIV: begin
          rem_d   = div_ge ? 17'(div_trial - 18'(den_q)) : 17'(div_trial);
          dbits_d = dbits_q << 1;
          quo_d   = div_quo;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd16) begin
            belief_d = (div_quo > 17'h0FFFF) ? 16'hFFFF : 16'(div_quo);
          end
        end
        default: ;
      endcase
    end

    // Every fresh scan starts from index 0 with an empty best
    if (policy_load || (state_d == S_SCAN && state_q != S_SCAN)) begin
      idx_d      = 4'd0;
      best_d     = 33'd0;
      best_idx_d = 4'd0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alpha_q     <= '0;
      act_tab_q   <= '0;
      belief_q    <= 16'd0;
      policy_ok_q <= 1'b0;
      idx_q       <= 4'd0;
      best_q      <= 33'd0;
      best_idx_q  <= 4'd0;
      last_act_q  <= 2'd0;
      obs_q       <= 1'b0;
      den_q       <= 17'd0;
      rem_q       <= 17'd0;
      dbits_q     <= 17'd0;
      quo_q       <= 17'd0;
      cnt_q       <= 5'd0;
    end else begin
      alpha_q     <= alpha_d;
      act_tab_q   <= act_tab_d;
      belief_q    <= belief_d;
      policy_ok_q <= policy_ok_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      last_act_q  <= last_act_d;
      obs_q       <= obs_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
      dbits_q     <= dbits_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef PBVI_EXEC_STEP_CNT_EN
  logic [15:0] step_q, step_d;

  // Saturating count of action handshakes since the last policy load
  always_comb begin
    step_d = step_q;
    if (policy_load)                          step_d = 16'd0;
    else if (act_fire && step_q != 16'hFFFF)  step_d = step_q + 16'd1;
  end

  // Step counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_q <= 16'd0;
    else     step_q <= step_d;
  end

  assign step_cnt = step_q;
`endif

endmodule

// File: tb/tb_pbvi_policy_exec.sv
// tb/tb_pbvi_policy_exec.sv - randomized and directed bench for pbvi_policy_exec with behavioural model
module tb_pbvi_policy_exec;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        policy_load;
  logic [15:0][1:0][15:0]      alpha_in;
  logic [15:0][1:0]            action_in;
  logic [2:0][1:0][1:0][15:0]  trans;
  logic [2:0][1:0][1:0][15:0]  observe;
  logic [15:0]                 belief_init;
  logic                        obs_valid;
  logic                        obs;
  logic                        obs_ready;
  logic                        act_valid;
  logic                        act_ready;
  logic [1:0]                  action;
  logic [15:0]                 belief_out;
  logic                        policy_ok;
`ifdef PBVI_EXEC_STEP_CNT_EN
  logic [15:0]                 step_cnt;
`endif

  always #5 clk = ~clk;

  pbvi_policy_exec dut (
    .clk         (clk),
    .rst         (rst),
    .policy_load (policy_load),
    .alpha_in    (alpha_in),
    .action_in   (action_in),
    .trans       (trans),
    .observe     (observe),
    .belief_init (belief_init),
    .obs_valid   (obs_valid),
    .obs         (obs),
    .obs_ready   (obs_ready),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .action      (action),
    .belief_out  (belief_out),
    .policy_ok   (policy_ok)
`ifdef PBVI_EXEC_STEP_CNT_EN
    ,
    .step_cnt    (step_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: phases of the decide/act/observe loop with cycle counts
  localparam int M_IDLE  = 0;
  localparam int M_SCAN  = 1;
  localparam int M_OFFER = 2;
  localparam int M_WAIT  = 3;
  localparam int M_BUSY  = 4;

  int     m_mode   = M_IDLE;
  int     m_cnt    = 0;
  int     m_belief = 0;
  int     m_pend   = 0;
  bit     m_ok     = 1'b0;
  int     m_action = 0;
  int     m_last   = 0;
  int     m_step   = 0;
  int     m_alpha[16][2];
  int     m_act[16];
  int     m_u0, m_u1;
  longint m_q;

  function automatic int model_choice(input int b0);
    longint best = -1;
    longint v;
    int     bi = 0;
    for (int i = 0; i < 16; i++) begin
      v = longint'(m_alpha[i][0]) * b0 + longint'(m_alpha[i][1]) * (65535 - b0);
      if (v > best) begin
        best = v;
        bi   = i;
      end
    end
    return m_act[bi];
  endfunction

  function automatic void model_evidence(input int a, input int o, input int b0,
                                         output int u0, output int u1);
    int     ai = (a == 3) ? 2 : a;
    longint b1 = 65535 - b0;
    longint p0, p1;
    p0 = (longint'(trans[ai][0][0]) * b0 + longint'(trans[ai][1][0]) * b1) >> 16;
    p1 = (longint'(trans[ai][0][1]) * b0 + longint'(trans[ai][1][1]) * b1) >> 16;
    u0 = int'((longint'(observe[ai][0][o]) * p0) >> 16);
    u1 = int'((longint'(observe[ai][1][o]) * p1) >> 16);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_belief = 0; m_ok = 1'b0;
      m_action = 0; m_last = 0; m_step = 0;
    end else if (policy_load) begin
      for (int i = 0; i < 16; i++) begin
        m_alpha[i][0] = int'(alpha_in[i][0]);
        m_alpha[i][1] = int'(alpha_in[i][1]);
        m_act[i]      = int'(action_in[i]);
      end
      m_belief = int'(belief_init);
      m_ok     = 1'b1;
      m_mode   = M_SCAN;
      m_cnt    = 16;
      m_step   = 0;
    end else begin
      case (m_mode)
        M_SCAN: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_mode   = M_OFFER;
            m_action = model_choice(m_belief);
          end
        end
        M_OFFER: if (act_ready) begin
          m_last = m_action;
          if (m_step < 65535) m_step++;
          m_mode = M_WAIT;
        end
        M_WAIT: if (obs_valid) begin
          model_evidence(m_last, int'(obs), m_belief, m_u0, m_u1);
          if (m_u0 + m_u1 == 0) begin
            m_pend = m_belief;
            m_cnt  = 1;
          end else begin
            m_q    = (longint'(m_u0) << 16) / (m_u0 + m_u1);
            m_pend = (m_q > 65535) ? 65535 : int'(m_q);
            m_cnt  = 18;
          end
          m_mode = M_BUSY;
        end
        M_BUSY: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_belief = m_pend;
            m_mode   = M_SCAN;
            m_cnt    = 16;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("act_valid", act_valid, (m_mode == M_OFFER));
    chk("obs_ready", obs_ready, (m_mode == M_WAIT) && !policy_load);
    chk("action", action, (m_mode == M_OFFER) ? m_action : 0);
    chk("belief_out", belief_out, m_belief);
    chk("policy_ok", policy_ok, m_ok);
`ifdef PBVI_EXEC_STEP_CNT_EN
    chk("step_cnt", step_cnt, m_step);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    policy_load = 1'b1;
    step();
    policy_load = 1'b0;
  endtask

  task automatic wait_act(output int k);
    k = 1;
    while (!act_valid && k < 60) begin
      step();
      k++;
    end
  endtask

  task automatic handshake();
    act_ready = 1'b1;
    step();
    act_ready = 1'b0;
  endtask

  task automatic give_obs(input logic o);
    obs       = o;
    obs_valid = 1'b1;
    step();
    obs_valid = 1'b0;
  endtask

  task automatic rand_policy();
    for (int i = 0; i < 16; i++) begin
      alpha_in[i][0] = 16'($urandom_range(0, 65535));
      alpha_in[i][1] = 16'($urandom_range(0, 65535));
      action_in[i]   = 2'($urandom_range(0, 3));
    end
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 2; s++)
        for (int t = 0; t < 2; t++) begin
          trans[a][s][t]   = 16'($urandom_range(0, 65535));
          observe[a][s][t] = 16'($urandom_range(0, 65535));
        end
    if ($urandom_range(0, 3) == 0) observe[$urandom_range(0, 2)] = '0;
    case ($urandom_range(0, 5))
      0:       belief_init = 16'h0000;
      1:       belief_init = 16'hFFFF;
      default: belief_init = 16'($urandom_range(0, 65535));
    endcase
  endtask

  int k;

  initial begin
    rst = 1'b0; policy_load = 1'b0; obs_valid = 1'b0; obs = 1'b0; act_ready = 1'b0;
    alpha_in = '0; action_in = '0; trans = '0; observe = '0; belief_init = 16'd0;
    #1 rst = 1'b1;
    step(); step(); step();
    chk("rst_act_valid", act_valid, 0);
    chk("rst_obs_ready", obs_ready, 0);
    chk("rst_action", action, 0);
    chk("rst_belief", belief_out, 0);
    chk("rst_policy_ok", policy_ok, 0);
    rst = 1'b0;
    step(); step();
    chk("idle_policy_ok", policy_ok, 0);

    // Tie: every value is zero, index 0 wins
    rand_policy();
    alpha_in = '0; action_in = '0; action_in[0] = 2'd1;
    pulse_load();
    wait_act(k);
    chk("tie_latency", k, 17);
    chk("tie_action", action, 1);
    handshake();
    chk("tie_obs_ready", obs_ready, 1);

    // Argmax: vector 5 dominates at b0=0.5
    for (int i = 0; i < 16; i++) begin
      alpha_in[i][0] = 16'h4000; alpha_in[i][1] = 16'h4000; action_in[i] = 2'd0;
    end
    alpha_in[5][0] = 16'hFFFF; alpha_in[5][1] = 16'h0000; action_in[5] = 2'd2;
    belief_init = 16'h8000;
    pulse_load();
    wait_act(k);
    chk("argmax_latency", k, 17);
    chk("argmax_action", action, 2);

    // Update with action 2, obs 0
    action_in = {16{2'd2}};
    trans[2][0][0] = 16'hFFFF; trans[2][0][1] = 16'h0000;
    trans[2][1][0] = 16'h0000; trans[2][1][1] = 16'hFFFF;
    observe[2][0][0] = 16'd55706; observe[2][0][1] = 16'd9830;
    observe[2][1][0] = 16'd9830;  observe[2][1][1] = 16'd55706;
    belief_init = 16'h8000;
    pulse_load();
    wait_act(k);
    handshake();
    give_obs(1'b0);
    k = 0;
    while (belief_out == 16'h8000 && k < 60) begin
      step();
      k++;
    end
    chk("update_latency", k, 18);
    chk("update_belief", belief_out, 55707);
    chk("model_belief", m_belief, 55707);
    wait_act(k);
    chk("rescan_latency", k, 17);

    // Zero evidence: no division, belief unchanged
    observe = '0;
    belief_init = 16'h1234;
    pulse_load();
    wait_act(k);
    handshake();
    give_obs(1'b1);
    wait_act(k);
    chk("zero_ev_latency", k, 18);
    chk("zero_ev_belief", belief_out, 16'h1234);

    // Preempt an offered action
    chk("preempt_pre_valid", act_valid, 1);
    belief_init = 16'h4321;
    pulse_load();
    chk("preempt_valid", act_valid, 0);
    chk("preempt_belief", belief_out, 16'h4321);
`ifdef PBVI_EXEC_STEP_CNT_EN
    chk("preempt_step0", step_cnt, 0);
`endif
    wait_act(k);
    chk("preempt_latency", k, 17);
    handshake();
`ifdef PBVI_EXEC_STEP_CNT_EN
    chk("preempt_step1", step_cnt, 1);
`endif
    give_obs(1'b0);
    wait_act(k);
    handshake();
`ifdef PBVI_EXEC_STEP_CNT_EN
    chk("preempt_step2", step_cnt, 2);
`endif

    // Reset in the middle of a scan
    pulse_load();
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    chk("midrst_act_valid", act_valid, 0);
    chk("midrst_belief", belief_out, 0);
    chk("midrst_policy_ok", policy_ok, 0);
    chk("midrst_action", action, 0);
    chk("midrst_obs_ready", obs_ready, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("post_rst_obs_ready", obs_ready, 0);
    chk("post_rst_act_valid", act_valid, 0);
    chk("post_rst_policy_ok", policy_ok, 0);

    // Randomized run checked every cycle by the model
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        act_ready = 1'b0; obs_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if (!m_ok || $urandom_range(0, 199) == 0) begin
        rand_policy();
        act_ready = 1'($urandom_range(0, 1));
        obs_valid = 1'($urandom_range(0, 1));
        pulse_load();
      end else begin
        act_ready = ($urandom_range(0, 2) == 0);
        obs_valid = 1'($urandom_range(0, 1));
        obs       = 1'($urandom_range(0, 1));
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
